// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
// Shares the write port and read port 1 of a small register file between two
// requesters with round-robin arbitration, a valid/ready request handshake and
// a one-cycle-latency response. After every reset release an init sequence
// writes zero to every register before requests are granted.
// Optional feature macro: REGFILE_ARB_STATS_EN adds saturating per-requester
// grant counters (grant_count0/grant_count1, CNT_WIDTH bits each).
module regfile_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 2,
`ifdef REGFILE_ARB_STATS_EN
  parameter int CNT_WIDTH  = 16,
`endif
  localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_register,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_register1,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  output logic                  init_done
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  grant_count0,
  output logic [CNT_WIDTH-1:0]  grant_count1
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_idx_q, init_idx_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   rd_reg_q, rd_reg_d;
  logic                    resp0_valid_q, resp0_valid_d;
  logic                    resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0]   resp0_rdata_q, resp0_rdata_d;
  logic [DATA_WIDTH-1:0]   resp1_rdata_q, resp1_rdata_d;

  logic                    run;
  logic                    grant0;
  logic                    grant1;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Round-robin grant: a lone requester wins, on contention the one not granted last wins
  always_comb begin
    run       = (state_q == ST_RUN);
    grant0    = run && req0_valid && (!req1_valid || last_grant_q);
    grant1    = run && req1_valid && (!req0_valid || !last_grant_q);
    sel_write = grant1 ? req1_write : req0_write;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
  end

  // Init sequencer: one zero write per register, then stay in RUN until reset
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      if (init_idx_q == LAST_IDX) begin
        state_d    = ST_RUN;
        init_idx_d = '0;
      end else begin
        init_idx_d = init_idx_q + 1'b1;
      end
    end
  end

  // Register-file port drive and response capture; the init write is held off while reset is low
  always_comb begin
    rf_write_enable   = 1'b0;
    rf_write_register = '0;
    rf_write_data     = '0;
    rd_reg_d          = rd_reg_q;
    last_grant_d      = last_grant_q;
    resp0_valid_d     = grant0;
    resp1_valid_d     = grant1;
    resp0_rdata_d     = resp0_rdata_q;
    resp1_rdata_d     = resp1_rdata_q;
    if (state_q == ST_INIT) begin
      rf_write_enable   = reset;
      rf_write_register = init_idx_q;
    end else if (grant0 || grant1) begin
      last_grant_d = grant1;
      if (sel_write) begin
        rf_write_enable   = 1'b1;
        rf_write_register = sel_addr;
        rf_write_data     = sel_wdata;
      end else begin
        rd_reg_d = sel_addr;
      end
      if (grant0) begin
        resp0_rdata_d = sel_write ? '0 : rf_read_data1;
      end
      if (grant1) begin
        resp1_rdata_d = sel_write ? '0 : rf_read_data1;
      end
    end
    rf_read_register1 = rd_reg_d;
  end

  // State, arbitration history and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      init_idx_q    <= '0;
      last_grant_q  <= 1'b1;
      rd_reg_q      <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      last_grant_q  <= last_grant_d;
      rd_reg_q      <= rd_reg_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;
  assign init_done   = (state_q == ST_RUN);

`ifdef REGFILE_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  // Grant counters count accepted requests and stick at all-ones
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (grant1 && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  // Grant counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
`endif

endmodule
